// File: rtl/serial_subtractor_nbit_if.sv
// Operand/result bus for the bit-serial subtractor.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid and ready are both high. The producer drives valid and
// the payload; the consumer drives ready. Ready and valid from the
// subtractor are decoded from registered state only, so neither one
// depends combinationally on the other side's signals.
interface serial_subtractor_nbit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    // Side that supplies operands and consumes results.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out
    );

    // The subtractor itself.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial unsigned subtractor: one operand pair is accepted, processed
// LSB first through a 1-bit subtract cell with a registered borrow, and the
// WIDTH-bit difference plus final borrow are presented until consumed.
module serial_subtractor_nbit #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_subtractor_nbit_if.slave  bus,
    output logic [1:0]               dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_subtractor_nbit: WIDTH must lie in 2..32");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic             borrow_q;
    logic [CW-1:0]    cnt_q;

    // Control strobes from the next-state decode.
    logic             accept;
    logic             shift_en;
    logic             last_bit;

    // 1-bit subtract cell on the current LSBs and the stored borrow.
    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_next;

    assign a0      = a_q[0];
    assign b0      = b_q[0];
    assign d_bit   = a0 ^ b0 ^ br_q;
    assign br_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        shift_en = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == LAST_BIT) begin
                    last_bit = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // Releasing a result always passes through IDLE, so a new
                // operand pair is never taken on the release edge.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            br_q  <= 1'b0;
            cnt_q <= '0;
        end else if (shift_en) begin
            a_q    <= a_q >> 1;
            b_q    <= b_q >> 1;
            // Each new difference bit enters at the MSB; after WIDTH shifts
            // bit 0 has reached the LSB position.
            diff_q <= {d_bit, diff_q[WIDTH-1:1]};
            br_q   <= br_next;
            cnt_q  <= cnt_q + CW'(1);
            if (last_bit) begin
                borrow_q <= br_next;
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign dbg_state      = state_q;

endmodule
